// File: rtl/block_stat_scheduler.sv
// Purpose: sequences the shared block-statistics RAM (segment accumulate, backlight readout, per-frame bank clear).
// Latency: an accumulate takes 2 RAM cycles (read, then write); a readout acks 2 cycles after rd_req when the RAM is idle.
// Backpressure: rd_req is held until rd_ack; one segment can be pending, and an extra segment is dropped and sets seg_ovf.
// Optional: define SCHED_DROP_CNT_EN to add the saturating drop_cnt output.
module block_stat_scheduler #(
    parameter int H_BLOCKS = 40,
    parameter int V_BLOCKS = 20,
    parameter int SEG_W    = 13,
    parameter int ACC_W    = 19,
    parameter int ADDR_W   = 11
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              vs,
    input  logic              seg_valid,
    input  logic [5:0]        seg_block_h,
    input  logic [5:0]        seg_block_v,
    input  logic [SEG_W-1:0]  seg_sum,
    input  logic              rd_req,
    input  logic [9:0]        rd_idx,
    output logic              rd_ack,
    output logic [ACC_W-1:0]  rd_data,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [ACC_W-1:0]  ram_wdata,
    input  logic [ACC_W-1:0]  ram_rdata,
    output logic              frame_done,
    output logic              bank,
`ifdef SCHED_DROP_CNT_EN
    output logic [15:0]       drop_cnt,
`endif
    output logic              seg_ovf
);

    localparam int IDX_W = ADDR_W - 1;
    localparam int N_BLK = H_BLOCKS * V_BLOCKS;
    localparam logic [5:0]       H_MAX    = 6'(H_BLOCKS);
    localparam logic [5:0]       V_MAX    = 6'(V_BLOCKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BLK - 1);

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [SEG_W-1:0] sum;
    } seg_t;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_READY, S_ACC_RD, S_ACC_WR, S_RD_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic              bank_q, bank_d;
    logic              frame_done_q, frame_done_d;
    logic              vs_q;
    logic              vs_flag_q, vs_flag_d;
    logic              pend_vld_q, pend_vld_d;
    seg_t              pend_q, pend_d;
    seg_t              wk_q, wk_d;
    logic [IDX_W-1:0]  clr_idx_q, clr_idx_d;
    logic              rd_inflight_q, rd_inflight_d;
    logic              rd_ack_q, rd_ack_d;
    logic [ACC_W-1:0]  rd_data_q, rd_data_d;
    logic              seg_ovf_q, seg_ovf_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;

    logic              vs_rise, seg_in_range, seg_ok, seg_taken, seg_drop;
    logic              launch, consume, rd_go, rd_issue, toggle;
    logic [IDX_W-1:0]  seg_h_m1, seg_v_m1;
    seg_t              seg_in;

    // Decode the incoming segment into a block index and validate its coordinates.
    always_comb begin
        seg_h_m1     = IDX_W'(seg_block_h) - IDX_W'(1);
        seg_v_m1     = IDX_W'(seg_block_v) - IDX_W'(1);
        seg_in.idx   = IDX_W'(seg_v_m1 * IDX_W'(H_BLOCKS) + seg_h_m1);
        seg_in.sum   = seg_sum;
        seg_in_range = (seg_block_h != 6'd0) && (seg_block_h <= H_MAX) &&
                       (seg_block_v != 6'd0) && (seg_block_v <= V_MAX);
        seg_ok       = seg_valid && seg_in_range &&
                       (state_q != S_IDLE) && (state_q != S_CLEAR);
        vs_rise      = vs && !vs_q;
        // A request whose ack is in flight or showing this cycle must not be served twice.
        rd_go        = rd_req && !rd_inflight_q && !rd_ack_q;
    end

    // Next-state, RAM port and pending-buffer logic.
    always_comb begin
        state_d    = state_q;
        clr_idx_d  = clr_idx_q;
        wk_d       = wk_q;
        vs_flag_d  = vs_flag_q;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        launch     = 1'b0;
        rd_issue   = 1'b0;
        toggle     = 1'b0;

        // Frame edges are remembered while working; edges during CLEAR are ignored.
        if (vs_rise && (state_q != S_IDLE) && (state_q != S_CLEAR)) begin
            vs_flag_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (vs_rise) begin
                    toggle    = 1'b1;
                    clr_idx_d = '0;
                    state_d   = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (rd_go) begin
                    // Readout steals the port; the clear step pauses this cycle.
                    ram_en   = 1'b1;
                    ram_addr = {~bank_q, rd_idx};
                    rd_issue = 1'b1;
                end else begin
                    ram_en   = 1'b1;
                    ram_we   = 1'b1;
                    ram_addr = {bank_q, clr_idx_q};
                    if (clr_idx_q == LAST_IDX) begin
                        state_d = S_READY;
                    end else begin
                        clr_idx_d = clr_idx_q + IDX_W'(1);
                    end
                end
            end
            S_READY: begin
                // A segment arriving this cycle counts as pending so it beats rd_req.
                if (pend_vld_q || seg_ok) begin
                    launch  = 1'b1;
                    wk_d    = pend_vld_q ? pend_q : seg_in;
                    state_d = S_ACC_RD;
                end else if (vs_flag_q) begin
                    toggle    = 1'b1;
                    vs_flag_d = 1'b0;
                    clr_idx_d = '0;
                    state_d   = S_CLEAR;
                end else if (rd_go) begin
                    ram_en   = 1'b1;
                    ram_addr = {~bank_q, rd_idx};
                    rd_issue = 1'b1;
                    state_d  = S_RD_WAIT;
                end
            end
            S_ACC_RD: begin
                ram_en   = 1'b1;
                ram_addr = {bank_q, wk_q.idx};
                state_d  = S_ACC_WR;
            end
            S_ACC_WR: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = {bank_q, wk_q.idx};
                ram_wdata = ram_rdata + {{(ACC_W-SEG_W){1'b0}}, wk_q.sum};
                state_d   = S_READY;
            end
            S_RD_WAIT: begin
                state_d = S_READY;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pending buffer, drop accounting, readout capture and bank bookkeeping.
    always_comb begin
        consume    = launch && pend_vld_q;
        seg_taken  = seg_ok && (!pend_vld_q || consume);
        seg_drop   = seg_valid && !seg_taken;
        pend_vld_d = pend_vld_q && !consume;
        pend_d     = pend_q;
        // A segment that launched straight from the input bypasses the buffer.
        if (seg_taken && !(launch && !pend_vld_q)) begin
            pend_vld_d = 1'b1;
            pend_d     = seg_in;
        end
        seg_ovf_d     = seg_ovf_q || seg_drop;
        drop_cnt_d    = drop_cnt_q;
        if (toggle) begin
            drop_cnt_d = '0;
        end else if (seg_drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
        rd_inflight_d = rd_issue;
        rd_ack_d      = rd_inflight_q;
        rd_data_d     = rd_inflight_q ? ram_rdata : rd_data_q;
        frame_done_d  = toggle;
        bank_d        = bank_q ^ toggle;
    end

    // State registers; reset aborts any operation in progress.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            bank_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            vs_q          <= 1'b0;
            vs_flag_q     <= 1'b0;
            pend_vld_q    <= 1'b0;
            pend_q        <= '0;
            wk_q          <= '0;
            clr_idx_q     <= '0;
            rd_inflight_q <= 1'b0;
            rd_ack_q      <= 1'b0;
            rd_data_q     <= '0;
            seg_ovf_q     <= 1'b0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            bank_q        <= bank_d;
            frame_done_q  <= frame_done_d;
            vs_q          <= vs;
            vs_flag_q     <= vs_flag_d;
            pend_vld_q    <= pend_vld_d;
            pend_q        <= pend_d;
            wk_q          <= wk_d;
            clr_idx_q     <= clr_idx_d;
            rd_inflight_q <= rd_inflight_d;
            rd_ack_q      <= rd_ack_d;
            rd_data_q     <= rd_data_d;
            seg_ovf_q     <= seg_ovf_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign rd_ack     = rd_ack_q;
    assign rd_data    = rd_data_q;
    assign frame_done = frame_done_q;
    assign bank       = bank_q;
    assign seg_ovf    = seg_ovf_q;
`ifdef SCHED_DROP_CNT_EN
    assign drop_cnt   = drop_cnt_q;
`else
    logic unused_drop_cnt;
    assign unused_drop_cnt = ^drop_cnt_q;
`endif

endmodule

// File: tb/tb_block_stat_scheduler.sv
// Bench for block_stat_scheduler: behavioural RAM, per-block total model, table vectors and corner sequences.
// Drives inputs 1 time unit after each rising edge and samples outputs at the same point.
// Build with SCHED_DROP_CNT_EN defined to also check drop_cnt.
module tb_block_stat_scheduler;

    localparam int ACC_W  = 19;
    localparam int SEG_W  = 13;
    localparam int ADDR_W = 11;

    logic              pclk = 1'b0;
    logic              rst, vs, seg_valid, rd_req;
    logic [5:0]        seg_block_h, seg_block_v;
    logic [SEG_W-1:0]  seg_sum;
    logic [9:0]        rd_idx;
    logic              rd_ack, ram_en, ram_we, frame_done, bank, seg_ovf;
    logic [ACC_W-1:0]  rd_data, ram_wdata, ram_rdata;
    logic [ADDR_W-1:0] ram_addr;
`ifdef SCHED_DROP_CNT_EN
    logic [15:0]       drop_cnt;
`endif

    block_stat_scheduler dut (
        .pclk(pclk), .rst(rst), .vs(vs), .seg_valid(seg_valid),
        .seg_block_h(seg_block_h), .seg_block_v(seg_block_v), .seg_sum(seg_sum),
        .rd_req(rd_req), .rd_idx(rd_idx), .rd_ack(rd_ack), .rd_data(rd_data),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .frame_done(frame_done), .bank(bank),
`ifdef SCHED_DROP_CNT_EN
        .drop_cnt(drop_cnt),
`endif
        .seg_ovf(seg_ovf)
    );

    always #5 pclk = ~pclk;

    // Single-port RAM with registered read, plus write/enable/frame monitors.
    logic [ACC_W-1:0]  mem [0:2047];
    logic              fill_req = 1'b0, fill_bank = 1'b0, poke_en = 1'b0;
    logic [ADDR_W-1:0] poke_addr = '0, last_wr_addr = '0, fd_last_wr = '0;
    logic [ACC_W-1:0]  poke_data = '0;
    int                wr_cnt0 = 0, wr_cnt1 = 0, en_cnt = 0, fd_cnt = 0;

    function automatic logic [ACC_W-1:0] pat(input logic b, input int i);
        return ACC_W'(i * 37 + (b ? 1000 : 0) + 5);
    endfunction

    always @(posedge pclk) begin
        if (frame_done) begin
            fd_cnt     <= fd_cnt + 1;
            fd_last_wr <= last_wr_addr;
        end
        if (ram_en) begin
            en_cnt <= en_cnt + 1;
            if (ram_we) begin
                mem[ram_addr] <= ram_wdata;
                last_wr_addr  <= ram_addr;
                if (ram_addr[10]) wr_cnt1 <= wr_cnt1 + 1;
                else              wr_cnt0 <= wr_cnt0 + 1;
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
        if (fill_req) begin
            for (int i = 0; i < 1024; i++) mem[{fill_bank, 10'(i)}] <= pat(fill_bank, i);
        end else if (poke_en) begin
            mem[poke_addr] <= poke_data;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Reference model: per-block totals of the bank currently being written.
    logic [ACC_W-1:0] exp_tot [0:1023];
    int               exp_drops = 0;

    function automatic logic in_range(input int h, input int v);
        return (h >= 1) && (h <= 40) && (v >= 1) && (v <= 20);
    endfunction

    task automatic model_seg(input int h, input int v, input int sum);
        if (in_range(h, v)) exp_tot[(v - 1) * 40 + (h - 1)] += ACC_W'(sum);
        else                exp_drops++;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 1024; i++) exp_tot[i] = '0;
        exp_drops = 0;
    endtask

    task automatic send_seg(input int h, input int v, input int sum);
        seg_valid   = 1'b1;
        seg_block_h = 6'(h);
        seg_block_v = 6'(v);
        seg_sum     = SEG_W'(sum);
        tick();
        seg_valid   = 1'b0;
    endtask

    task automatic do_read(input int idx, output logic [ACC_W-1:0] data, output int lat);
        rd_req = 1'b1;
        rd_idx = 10'(idx);
        lat    = 0;
        do begin
            tick();
            lat++;
        end while (!rd_ack && lat < 40);
        data   = rd_data;
        rd_req = 1'b0;
    endtask

    task automatic vs_pulse();
        vs = 1'b1;
        ticks(2);
        vs = 1'b0;
        tick();
    endtask

    task automatic do_fill(input logic b);
        fill_bank = b;
        fill_req  = 1'b1;
        tick();
        fill_req  = 1'b0;
    endtask

    task automatic do_poke(input logic [ADDR_W-1:0] a, input logic [ACC_W-1:0] d);
        poke_addr = a;
        poke_data = d;
        poke_en   = 1'b1;
        tick();
        poke_en   = 1'b0;
    endtask

    // Waits until the write counter of bank b reaches target; returns the cycles used.
    task automatic wait_writes(input logic b, input int target, input int budget, output int used);
        used = 0;
        while (((b ? wr_cnt1 : wr_cnt0) < target) && used < budget) begin
            tick();
            used++;
        end
    endtask

    function automatic int nonzero(input logic b);
        int c = 0;
        for (int i = 0; i < 800; i++) if (mem[{b, 10'(i)}] != '0) c++;
        return c;
    endfunction

    typedef struct {
        int h;
        int v;
        int sum;
        int exp_idx;
        bit exp_drop;
    } vec_t;

    initial begin
        vec_t              tbl [10];
        logic [ACC_W-1:0]  d;
        int                lat, used, w0, w1, e0, f0, bad;

        tbl[0] = '{1, 1, 7, 0, 1'b0};
        tbl[1] = '{40, 1, 11, 39, 1'b0};
        tbl[2] = '{1, 20, 13, 760, 1'b0};
        tbl[3] = '{40, 20, 8191, 799, 1'b0};
        tbl[4] = '{17, 9, 4000, 336, 1'b0};
        tbl[5] = '{0, 1, 5, 0, 1'b1};
        tbl[6] = '{41, 3, 5, 0, 1'b1};
        tbl[7] = '{2, 0, 5, 0, 1'b1};
        tbl[8] = '{2, 21, 5, 0, 1'b1};
        tbl[9] = '{63, 63, 5, 0, 1'b1};

        rst = 1'b1; vs = 1'b0; seg_valid = 1'b0; rd_req = 1'b0;
        seg_block_h = '0; seg_block_v = '0; seg_sum = '0; rd_idx = '0;
        model_clear();
        tick();
        do_fill(1'b0);
        do_fill(1'b1);

        // Reset values.
        check("rst_rd_ack", rd_ack, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_ram_en", ram_en, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_bank", bank, 0);
        check("rst_seg_ovf", seg_ovf, 0);
        rst = 1'b0;
        ticks(3);
        check("idle_no_ram_ops", en_cnt, 0);

        // First frame edge: full clear of bank 1.
        w1 = wr_cnt1; w0 = wr_cnt0; f0 = fd_cnt;
        vs_pulse();
        wait_writes(1'b1, w1 + 800, 2000, used);
        check("clear1_timeout", (used < 2000), 1);
        ticks(5);
        check("clear1_writes", wr_cnt1 - w1, 800);
        check("clear1_other_bank", wr_cnt0 - w0, 0);
        check("clear1_zero", nonzero(1'b1), 0);
        check("clear1_bank", bank, 1);
        check("clear1_frame_done", fd_cnt - f0, 1);
        model_clear();

        // Two segments on block (3,2), 32 cycles apart, each a 2-cycle RMW.
        e0 = en_cnt; w1 = wr_cnt1;
        send_seg(3, 2, 100); model_seg(3, 2, 100);
        ticks(31);
        send_seg(3, 2, 200); model_seg(3, 2, 200);
        ticks(5);
        check("acc_42", mem[{1'b1, 10'd42}], 300);
        check("acc_ram_cycles", en_cnt - e0, 4);
        check("acc_writes", wr_cnt1 - w1, 2);

        // Segment and readout together: ready(launch), acc_rd, acc_wr, ready(read), rd_wait, ack.
        seg_valid = 1'b1; seg_block_h = 6'd3; seg_block_v = 6'd2; seg_sum = 13'd50;
        rd_req = 1'b1; rd_idx = 10'd42;
        model_seg(3, 2, 50);
        lat = 0;
        do begin
            tick();
            seg_valid = 1'b0;
            lat++;
        end while (!rd_ack && lat < 40);
        d = rd_data;
        rd_req = 1'b0;
        check("prio_ack_latency", lat, 5);
        check("prio_rd_data_bank0", d, pat(1'b0, 42));
        check("prio_acc_42", mem[{1'b1, 10'd42}], 350);

        // Idle readout latency.
        ticks(2);
        do_read(100, d, lat);
        check("idle_ack_latency", lat, 2);
        check("idle_rd_data", d, pat(1'b0, 100));
        tick();
        check("ack_one_cycle", rd_ack, 0);

        // Three back-to-back segments: first two accepted, third dropped.
        ticks(2);
        send_seg(1, 1, 1);
        send_seg(1, 1, 2);
        send_seg(1, 1, 4);
        exp_tot[0] += 3;
        exp_drops++;
        ticks(8);
        check("b2b_acc_0", mem[{1'b1, 10'd0}], exp_tot[0]);
        check("b2b_seg_ovf", seg_ovf, 1);
`ifdef SCHED_DROP_CNT_EN
        check("b2b_drop_cnt", drop_cnt, 1);
`endif

        // Table of block coordinates, including out-of-range rejects.
        for (int i = 0; i < 10; i++) begin
            w1 = wr_cnt1;
            send_seg(tbl[i].h, tbl[i].v, tbl[i].sum);
            if (tbl[i].exp_drop) exp_drops++;
            else exp_tot[tbl[i].exp_idx] += ACC_W'(tbl[i].sum);
            ticks(6);
            if (tbl[i].exp_drop) begin
                check($sformatf("tbl%0d_no_write", i), wr_cnt1 - w1, 0);
            end else begin
                check($sformatf("tbl%0d_writes", i), wr_cnt1 - w1, 1);
                check($sformatf("tbl%0d_total", i), mem[{1'b1, 10'(tbl[i].exp_idx)}], exp_tot[tbl[i].exp_idx]);
            end
`ifdef SCHED_DROP_CNT_EN
            check($sformatf("tbl%0d_drop_cnt", i), drop_cnt, exp_drops);
`endif
        end

        // Accumulation wraps modulo 2^ACC_W.
        do_poke({1'b1, 10'd5}, 19'h7FFF6);
        exp_tot[5] = 19'h7FFF6;
        send_seg(6, 1, 100); model_seg(6, 1, 100);
        ticks(5);
        check("wrap_total", mem[{1'b1, 10'd5}], 90);

        // Randomized segments, spaced so none collide.
        for (int i = 0; i < 60; i++) begin
            int h, v, s;
            h = ($urandom_range(0, 7) == 0) ? 41 : $urandom_range(1, 40);
            v = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 20);
            s = $urandom_range(0, 8191);
            send_seg(h, v, s);
            model_seg(h, v, s);
            ticks($urandom_range(3, 8));
        end
        check("rand_seg_ovf", seg_ovf, 1);
`ifdef SCHED_DROP_CNT_EN
        check("rand_drop_cnt", drop_cnt, exp_drops);
`endif

        // Frame edge while an RMW is reading: RMW lands in old bank, then toggle.
        ticks(3);
        f0 = fd_cnt; w0 = wr_cnt0;
        send_seg(5, 5, 77);
        model_seg(5, 5, 77);
        vs = 1'b1;
        used = 0;
        while (fd_cnt == f0 && used < 30) begin
            tick();
            used++;
            if (used == 3) vs = 1'b0;
        end
        vs = 1'b0;
        check("vs_rmw_frame_done", fd_cnt - f0, 1);
        check("vs_rmw_last_old_write", fd_last_wr, {1'b1, 10'd164});
        check("vs_rmw_total", mem[{1'b1, 10'd164}], exp_tot[164]);
        check("vs_rmw_bank", bank, 0);
`ifdef SCHED_DROP_CNT_EN
        check("vs_rmw_drop_cnt", drop_cnt, 0);
`endif

        // Read back the whole finished frame while bank 0 is clearing.
        bad = 0;
        for (int i = 0; i < 800; i++) begin
            do_read(i, d, lat);
            if (lat >= 40 || d !== exp_tot[i]) begin
                bad++;
                if (bad <= 8) $display("FAIL readback idx %0d: got %0d, expected %0d", i, d, exp_tot[i]);
            end
        end
        check("readback_errors", bad, 0);
        wait_writes(1'b0, w0 + 800, 4000, used);
        check("clear0_timeout", (used < 4000), 1);
        ticks(5);
        check("clear0_writes", wr_cnt0 - w0, 800);
        check("clear0_zero", nonzero(1'b0), 0);
        do_read(164, d, lat);
        check("post_clear_latency", lat, 2);
        check("post_clear_data", d, exp_tot[164]);

        // Reset in the middle of a clear, then a full restart.
        ticks(2);
        w1 = wr_cnt1;
        vs_pulse();
        ticks(100);
        check("midclear_bank", bank, 1);
        check("midclear_partial", ((wr_cnt1 - w1) > 0) && ((wr_cnt1 - w1) < 800), 1);
        rst = 1'b1;
        #1;
        check("midrst_ram_en", ram_en, 0);
        check("midrst_ram_we", ram_we, 0);
        check("midrst_ram_addr", ram_addr, 0);
        check("midrst_bank", bank, 0);
        check("midrst_seg_ovf", seg_ovf, 0);
        check("midrst_frame_done", frame_done, 0);
        check("midrst_rd_ack", rd_ack, 0);
        tick();
        do_fill(1'b1);
        rst = 1'b0;
        e0 = en_cnt;
        ticks(20);
        check("postrst_idle", en_cnt - e0, 0);
        w1 = wr_cnt1;
        vs_pulse();
        wait_writes(1'b1, w1 + 800, 2000, used);
        check("reclear_timeout", (used < 2000), 1);
        ticks(5);
        check("reclear_writes", wr_cnt1 - w1, 800);
        check("reclear_zero", nonzero(1'b1), 0);
        check("reclear_bank", bank, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
